reset_release_sequencer: RTL and testbench
==========================================

# reset_release_sequencer

Staged reset-release controller: the consumer-side counterpart of `synchronous_reset_timer`. It takes one asynchronous reset request and releases `STAGES` downstream reset domains one after another, each only after the previous domain acknowledges readiness. It supervises every released domain with a ready handshake and a timeout, and re-applies reset to all domains on failure. It sits between the board/system reset source and the clocked subsystems (PLL consumers, memories, cores) that must come out of reset in a fixed order.

## Interface
- `STAGES`, 4: number of reset domains; 1..32.
- `HOLD`, 8: cycles each stage stays in reset after its release is enabled; ≥1.
- `TIMEOUT`, 255: cycles allowed for a released stage to raise ready; ≥1.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_in`  in  1  asynchronous, active-high reset; asserts asynchronously, deasserts internally through a 2-flop synchronizer.
- `reset_out`  out  STAGES  per-domain reset, active-high; bit i belongs to stage i.
- `stage_ready`  in  STAGES  per-domain acknowledge, synchronous to `clk`; high = domain i is up.
- `all_ready`  out  1  high when every stage is released and acknowledged.
- `timeout_error`  out  1  sticky; a stage missed its TIMEOUT.
- `dropout_error`  out  1  sticky; an acknowledged stage dropped `stage_ready`.

## Operation
- While `reset_in` is high: `reset_out` = all ones, `all_ready`=0, both error flags=0, state SYNC, stage index=0, counter=0. These are the reset values of every output.
- States: SYNC → HOLD → WAIT → (HOLD for the next stage | DONE).
- SYNC: wait for the synchronizer to deassert, then go to HOLD with counter=0.
- HOLD(i): count HOLD cycles, then clear `reset_out[i]` and enter WAIT(i).
- WAIT(i): `stage_ready[i]` sampled high → if i=STAGES-1 enter DONE, else i+1, HOLD. Sampled low on TIMEOUT consecutive edges → timeout restart.
- DONE: `all_ready`=1; remain until restart or `reset_in`.
- Dropout: in any state, `stage_ready[j]` sampled low for a stage j already acknowledged → dropout restart.
- Restart, timeout or dropout: on that edge set `reset_out` to all ones, `all_ready`=0, set the matching sticky flag, stage index=0, enter HOLD. There is no SYNC delay and no retry limit.
- Simultaneous timeout and dropout on one edge: set both flags and perform a single restart.
- `stage_ready` of unreleased stages and of the stage under WAIT before its first high sample is ignored for dropout purposes.
- Released bits stay low; `reset_out` only ever goes to all ones as a whole.
- Counter width is `$clog2(max(HOLD,TIMEOUT)+1)`. The counter clears on every state entry and never wraps.

## Timing
- Let E1 be the first rising edge at which `reset_in` is low. Synchronizer output falls at E2. `reset_out[0]` falls after edge E(HOLD+2).
- Acknowledge of stage i sampled at edge W → `reset_out[i+1]` falls after W+HOLD; for the last stage, `all_ready` rises after W.
- Release after edge R → timeout fires at R+TIMEOUT if ready is low at edges R+1..R+TIMEOUT. Stage 0 then falls again at R+TIMEOUT+HOLD.
- Dropout sampled at edge D → all `reset_out` high and `all_ready` low after D.
- `reset_in` assertion at any time, including mid-cycle: outputs reach reset values asynchronously, with no clock needed. A pulse shorter than one clock still yields the full sequence.

## Test plan
- STAGES=3, HOLD=4, TIMEOUT=10; `reset_in` high 5 cycles then low; each ready rises 2 cycles after its release → `reset_out[0]` falls after E6, `[1]` after E12, `[2]` after E18, `all_ready`=1 after E20, error flags 0.
- Same setup, `stage_ready[1]` stuck low → released after E12, `timeout_error`=1 and `reset_out`=3'b111 after E22, `reset_out[0]` falls again after E26.
- In DONE, drop `stage_ready[0]` for one cycle → the next edge gives `reset_out`=3'b111, `all_ready`=0, `dropout_error`=1, and the sequence restarts from stage 0 with HOLD=4.
- Assert `reset_in` between edges during WAIT(1) → `reset_out`=3'b111 and flags cleared immediately. After release, the timing matches the first scenario.
- STAGES=1, HOLD=1, TIMEOUT=1, `stage_ready` tied high → `reset_out[0]` falls after E3, `all_ready` rises after E4.
- Sub-cycle `reset_in` glitch (0.4 clock period) after DONE → full sequence replayed from SYNC, with flags cleared.

Source files
------------

// File: rtl/reset_release_sequencer.sv
// Staged reset-release controller.
// Releases STAGES reset domains in order, each after a HOLD-cycle delay and
// only once the previous domain has acknowledged. Released domains are
// supervised: a missing acknowledge (TIMEOUT) or a lost acknowledge
// (dropout) re-applies reset to every domain and restarts from stage 0.
`timescale 1ns/1ps
module reset_release_sequencer #(
    parameter int STAGES  = 4,
    parameter int HOLD    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_in,
    output logic [STAGES-1:0] reset_out,
    input  logic [STAGES-1:0] stage_ready,
    output logic              all_ready,
    output logic              timeout_error,
    output logic              dropout_error
);

    localparam int CNT_MAX = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(STAGES - 1);
    localparam logic [STAGES-1:0] ONE_HOT0    = STAGES'(1);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    logic [1:0]        sync_q;
    state_e            state_q,       state_d;
    logic [IDX_W-1:0]  idx_q,         idx_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [STAGES-1:0] reset_out_q,   reset_out_d;
    logic [STAGES-1:0] acked_q,       acked_d;
    logic              all_ready_q,   all_ready_d;
    logic              timeout_q,     timeout_d;
    logic              dropout_q,     dropout_d;

    logic [STAGES-1:0] cur_mask_s;
    logic              ack_s;
    logic              timeout_s;
    logic              dropout_s;

    // Two-flop reset synchronizer: set asynchronously, cleared one flop per edge.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_SYNC;
            idx_q       <= '0;
            cnt_q       <= '0;
            reset_out_q <= '1;
            acked_q     <= '0;
            all_ready_q <= 1'b0;
            timeout_q   <= 1'b0;
            dropout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            reset_out_q <= reset_out_d;
            acked_q     <= acked_d;
            all_ready_q <= all_ready_d;
            timeout_q   <= timeout_d;
            dropout_q   <= dropout_d;
        end
    end

    // Next-state logic: stage progression, supervision and restart.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        reset_out_d = reset_out_q;
        acked_d     = acked_q;
        all_ready_d = all_ready_q;
        timeout_d   = timeout_q;
        dropout_d   = dropout_q;

        cur_mask_s  = ONE_HOT0 << idx_q;
        ack_s       = |(stage_ready & cur_mask_s);
        // Only stages that have already acknowledged can drop out.
        dropout_s   = |(acked_q & ~stage_ready);
        timeout_s   = 1'b0;

        case (state_q)
            ST_SYNC: begin
                // Leave on the edge where the synchronizer output falls.
                if (sync_q == 2'b10) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    reset_out_d = reset_out_q & ~cur_mask_s;
                    state_d     = ST_WAIT;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (ack_s) begin
                    acked_d = acked_q | cur_mask_s;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d     = ST_DONE;
                        all_ready_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_HOLD;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        // A single restart covers timeout, dropout, or both on the same edge.
        if (timeout_s || dropout_s) begin
            state_d     = ST_HOLD;
            idx_d       = '0;
            cnt_d       = '0;
            reset_out_d = '1;
            acked_d     = '0;
            all_ready_d = 1'b0;
            timeout_d   = timeout_q | timeout_s;
            dropout_d   = dropout_q | dropout_s;
        end else begin
            timeout_d   = timeout_q;
            dropout_d   = dropout_q;
        end
    end

    assign reset_out     = reset_out_q;
    assign all_ready     = all_ready_q;
    assign timeout_error = timeout_q;
    assign dropout_error = dropout_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: directed timing scenarios plus random
// handshakes, drops and reset pulses checked against a timestamp-based model.
`timescale 1ns/1ps
module tb_reset_release_sequencer;

    localparam int ST = 3;
    localparam int HD = 4;
    localparam int TO = 10;

    logic          clk         = 1'b0;
    logic          reset_in    = 1'b1;
    logic [ST-1:0] stage_ready = '0;
    logic [ST-1:0] reset_out;
    logic          all_ready, timeout_error, dropout_error;

    logic          rst1 = 1'b1;
    logic [0:0]    ro1;
    logic          ar1, te1, de1;

    always #5 clk = ~clk;

    reset_release_sequencer #(.STAGES(ST), .HOLD(HD), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_in(reset_in), .reset_out(reset_out),
        .stage_ready(stage_ready), .all_ready(all_ready),
        .timeout_error(timeout_error), .dropout_error(dropout_error));

    reset_release_sequencer #(.STAGES(1), .HOLD(1), .TIMEOUT(1)) dut1 (
        .clk(clk), .reset_in(rst1), .reset_out(ro1),
        .stage_ready(1'b1), .all_ready(ar1),
        .timeout_error(te1), .dropout_error(de1));

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
        end
    endtask

    // ---------------- reference model (absolute edge timestamps) -------------
    int            low_cnt, n_rel, n_ack, release_at, deadline;
    bit            m_sync;
    logic [ST-1:0] m_rst;
    logic          m_ar, m_te, m_de;

    function automatic void model_reset();
        m_rst = '1; m_ar = 1'b0; m_te = 1'b0; m_de = 1'b0;
        m_sync = 1'b1; low_cnt = 0; n_rel = 0; n_ack = 0;
        release_at = -1; deadline = -1;
    endfunction

    function automatic void model_edge(input logic rin, input logic [ST-1:0] rdy);
        bit drop, waiting, tmo, ack;
        if (rin) begin
            model_reset();
        end else if (m_sync) begin
            low_cnt++;
            if (low_cnt == 2) begin
                m_sync = 1'b0;
                release_at = edge_no + HD;
            end
        end else begin
            drop = 1'b0;
            for (int j = 0; j < n_ack; j++) if (!rdy[j]) drop = 1'b1;
            waiting = (n_rel == n_ack + 1);
            tmo = 1'b0;
            ack = 1'b0;
            if (waiting) begin
                ack = rdy[n_ack];
                tmo = !rdy[n_ack] && (edge_no == deadline);
            end
            if (drop || tmo) begin
                m_te = m_te | tmo;
                m_de = m_de | drop;
                m_rst = '1; m_ar = 1'b0; n_rel = 0; n_ack = 0;
                release_at = edge_no + HD;
            end else if (ack) begin
                n_ack++;
                if (n_ack == ST) m_ar = 1'b1;
                else release_at = edge_no + HD;
            end else if (n_rel == n_ack && n_rel < ST && edge_no == release_at) begin
                m_rst[n_rel] = 1'b0;
                n_rel++;
                deadline = edge_no + TO;
            end
        end
    endfunction

    // ---------------- stage_ready driver -------------------------------------
    bit            rand_mode = 1'b0;
    int            dly_dir [ST] = '{2, 2, 2};
    logic [ST-1:0] stuck    = '0;
    logic [ST-1:0] drop_req = '0;
    int            dly_cur  [ST];
    int            rel_edge [ST];
    bit            seen     [ST];

    // Each domain acknowledges a fixed number of edges after its release.
    always @(negedge clk) begin
        logic [ST-1:0] rdrop;
        rdrop = '0;
        for (int i = 0; i < ST; i++) begin
            if (reset_out[i]) begin
                seen[i] = 1'b0;
                stage_ready[i] = 1'b0;
            end else begin
                if (!seen[i]) begin
                    seen[i] = 1'b1;
                    rel_edge[i] = edge_no;
                    dly_cur[i] = rand_mode ? int'($urandom_range(1, 13)) : dly_dir[i];
                end
                stage_ready[i] = !stuck[i] && (edge_no + 1 >= rel_edge[i] + dly_cur[i]);
            end
        end
        if (rand_mode && $urandom_range(0, 59) == 0) rdrop[$urandom_range(0, ST-1)] = 1'b1;
        stage_ready = stage_ready & ~drop_req & ~rdrop;
    end

    // ---------------- event marks for directed timing checks -----------------
    int            e0;
    int            fall_first [ST];
    int            fall_last  [ST];
    int            ar_e, te_e;
    logic [ST-1:0] ro_at_te, prev_ro;
    logic          prev_ar, prev_te;

    function automatic void clear_marks();
        for (int i = 0; i < ST; i++) begin fall_first[i] = -1; fall_last[i] = -1; end
        ar_e = -1; te_e = -1; ro_at_te = '0;
        prev_ro = '1; prev_ar = 1'b0; prev_te = 1'b0;
    endfunction

    function automatic void monitor();
        int idx;
        idx = edge_no - e0;
        for (int i = 0; i < ST; i++) begin
            if (prev_ro[i] && !reset_out[i]) begin
                if (fall_first[i] < 0) fall_first[i] = idx;
                fall_last[i] = idx;
            end
        end
        if (!prev_ar && all_ready && ar_e < 0) ar_e = idx;
        if (!prev_te && timeout_error && te_e < 0) begin te_e = idx; ro_at_te = reset_out; end
        prev_ro = reset_out; prev_ar = all_ready; prev_te = timeout_error;
    endfunction

    task automatic step();
        @(posedge clk);
        edge_no++;
        if (reset_in) begin e0 = edge_no; clear_marks(); end
        model_edge(reset_in, stage_ready);
        #1;
        check("outs", {26'd0, reset_out, all_ready, timeout_error, dropout_error},
                      {26'd0, m_rst, m_ar, m_te, m_de});
        monitor();
    endtask

    task automatic apply_reset(input int n);
        reset_in = 1'b1;
        model_reset();
        repeat (n) step();
        reset_in = 1'b0;
    endtask

    // Asserts reset_in between edges and checks the asynchronous response.
    task automatic async_assert();
        #1 reset_in = 1'b1;
        model_reset();
        e0 = edge_no;
        clear_marks();
        #1 check("async_rst", {26'd0, reset_out, all_ready, timeout_error, dropout_error},
                              {26'd0, 3'b111, 3'b000});
    endtask

    task automatic glitch();
        async_assert();
        #3 reset_in = 1'b0;
    endtask

    task automatic check_nominal(input string tag);
        check({tag, "_f0"}, fall_first[0], 6);
        check({tag, "_f1"}, fall_first[1], 12);
        check({tag, "_f2"}, fall_first[2], 18);
        check({tag, "_ar"}, ar_e, 20);
        check({tag, "_flags"}, {timeout_error, dropout_error}, 2'b00);
    endtask

    initial begin
        int d1_fall, d1_ar, d_e, r;
        model_reset();
        e0 = 0;
        clear_marks();

        // Single-stage instance, HOLD=TIMEOUT=1, ready tied high.
        repeat (3) step();
        check("d1_rst", {ro1, ar1, te1, de1}, 4'b1000);
        rst1 = 1'b0;
        d1_fall = -1; d1_ar = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (ro1 == 1'b0 && d1_fall < 0) d1_fall = k;
            if (ar1 && d1_ar < 0) d1_ar = k;
        end
        check("d1_fall", d1_fall, 3);
        check("d1_ar", d1_ar, 4);
        check("d1_flags", {te1, de1}, 2'b00);

        // Nominal release sequence.
        apply_reset(5);
        check("rst_state", {reset_out, all_ready, timeout_error, dropout_error}, 6'b111000);
        repeat (22) step();
        check_nominal("s1");

        // Stage 1 never acknowledges.
        stuck = 3'b010;
        apply_reset(5);
        repeat (30) step();
        check("s2_f1", fall_first[1], 12);
        check("s2_te_edge", te_e, 22);
        check("s2_ro_at_te", ro_at_te, 3'b111);
        check("s2_refall0", fall_last[0], 26);
        stuck = '0;

        // Dropout of stage 0 while DONE.
        apply_reset(5);
        repeat (22) step();
        drop_req = 3'b001;
        step();
        drop_req = '0;
        d_e = edge_no - e0;
        check("s3_drop", {reset_out, all_ready, dropout_error}, 5'b11101);
        repeat (11) step();
        check("s3_refall0", fall_last[0], d_e + 4);

        // Reset asserted mid-cycle during WAIT(1), then a normal release.
        async_assert();
        repeat (3) step();
        reset_in = 1'b0;
        repeat (22) step();
        check_nominal("s4");

        // Sub-cycle glitch after DONE replays the whole sequence.
        repeat (2) step();
        glitch();
        repeat (22) step();
        check_nominal("s6");

        // Randomized handshakes, drops and resets against the model.
        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            step();
            r = int'($urandom_range(0, 299));
            if (r == 0) begin
                glitch();
            end else if (r == 1) begin
                async_assert();
                repeat ($urandom_range(1, 3)) step();
                reset_in = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
